cpu_sequencer: RTL and testbench
================================

# cpu_sequencer

Multi-cycle control sequencer for the 8-bit core. It fetches 16-bit instructions from instruction memory over a req/ack handshake and steps each one through FETCH, DECODE, EXECUTE and WRITEBACK. It drives the ALU B-input select (`instruction_type`), the literal/address field, the ALU opcode and the register-file/W write enables. It sits between instruction memory and the ALU/register-file datapath and is the only block that advances the program counter.

## Interface
Parameters:
- `RESET_PC`, 8'h00, program counter value after reset
- `WIDTH`, 8, datapath/address width (fixed at 8 in this core)

Ports:
- `clk`  in  1  system clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `run`  in  1  permission to start the next instruction fetch
- `imem_req`  out  1  instruction fetch request
- `imem_addr`  out  8  fetch address (current PC)
- `imem_ack`  in  1  fetch data valid this cycle
- `imem_data`  in  16  instruction word: [15:14] type, [13:10] opcode, [9:8] reserved, [7:0] literal/address
- `alu_zero`  in  1  ALU zero flag for the current operands
- `instruction_type`  out  2  to ALU B mux: bit0 = 0 literal, 1 register; bit1 = destination (0 W, 1 register file)
- `literal_or_address`  out  8  IR[7:0]
- `alu_op`  out  4  IR[13:10]
- `rf_we`  out  1  register-file write strobe
- `w_we`  out  1  W-register write strobe
- `halted`  out  1  core stopped by HALT

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
- Reset: state IDLE, PC=`RESET_PC`, IR=16'h0000. All outputs 0, except `imem_addr`=`RESET_PC`.
- IDLE: if `run`=1, go to FETCH; otherwise stay.
- FETCH:
  - Hold `imem_req`=1 and `imem_addr`=PC until `imem_ack`.
  - On ack: IR←`imem_data`, PC←PC+1 mod 256 (8'hFF wraps to 8'h00), go to DECODE.
  - `run` is ignored while a request is outstanding.
- DECODE: one cycle. `instruction_type`, `literal_or_address` and `alu_op` are driven from IR from this state until the next FETCH.
- EXECUTE: one cycle. Action by opcode:
  - 0000–0111 (ALU ops): go to WRITEBACK.
  - 1000 JMP: PC←IR[7:0], go to IDLE.
  - 1001 JZ: if `alu_zero`=1 (sampled this cycle), PC←IR[7:0]; go to IDLE.
  - 1111 HALT: go to HALT.
  - 1010–1110: treated as NOP, go to IDLE.
- WRITEBACK: one cycle. Pulse `rf_we` if type bit1=1, else pulse `w_we`; go to IDLE.
- HALT: `halted`=1. Leaves only on reset. `run` has no effect.
- `imem_ack` outside FETCH is ignored.

## Timing
- ALU instruction: 1 (IDLE) + N (fetch, N≥1 ack latency) + 1 + 1 + 1 cycles. With `run` held high and 1-cycle ack, one instruction completes every 5 cycles.
- Jump/NOP: WRITEBACK skipped (4 cycles with 1-cycle ack). The new PC is visible on `imem_addr` in the IDLE cycle after EXECUTE.
- `rf_we`/`w_we` are exactly one cycle wide and never both high.
- Write strobes are asserted only in WRITEBACK; `imem_req` only in FETCH.
- Reset asserted mid-fetch: `imem_req` drops asynchronously. An ack arriving after reset release and before the next request is ignored.
- All outputs are registered or decoded from state/IR only. No combinational path from `imem_ack` to any output.

## Structure
- Shared package `cpu_pkg`:
  - state enum
  - opcode constants: ALU range, `OP_JMP`, `OP_JZ`, `OP_HALT`
  - instruction field positions
  - `TYPE_LITERAL`/`TYPE_REGISTER` encodings, which the B-input mux also uses
- One natural sub-module: `program_counter` (load, increment with wrap, async reset to `RESET_PC`).

## Test plan
- Reset then `run`=1, IR=16'h0105 (type 00, op 0000, lit 05), 1-cycle ack → `instruction_type`=00, `literal_or_address`=8'h05, `w_we` one pulse at cycle 5, PC=1.
- Type 11 instruction 16'hC0xx with ack delayed 3 cycles → `imem_req` high for 3 cycles, `rf_we` pulse, `w_we` never high.
- PC=8'hFF fetch → PC wraps to 8'h00. JMP 16'h2042 → next `imem_addr`=8'h42.
- JZ 16'h2410: `alu_zero`=1 → next fetch at 8'h10; `alu_zero`=0 → next fetch at PC+1.
- HALT 16'h3C00 → `halted`=1 and no further `imem_req` for 20 cycles despite `run`=1.
- `reset_n` pulsed low during an outstanding fetch → `imem_req`=0 immediately, PC=`RESET_PC`, late ack ignored.

Source files
------------

// File: rtl/cpu_sequencer_pkg.sv
// cpu_pkg: shared definitions for the 8-bit core control path.
//   - state_t: sequencer FSM states
//   - opcode constants (ALU range, JMP, JZ, HALT)
//   - instruction word field positions
//   - instruction_type bit encodings, shared with the ALU B-input mux
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } state_t;

  localparam int INSTR_W = 16;

  // Instruction word layout: [15:14] type, [13:10] opcode, [9:8] reserved, [7:0] literal/address
  localparam int TYPE_HI = 15;
  localparam int TYPE_LO = 14;
  localparam int OP_HI   = 13;
  localparam int OP_LO   = 10;
  localparam int RSV_HI  = 9;
  localparam int RSV_LO  = 8;
  localparam int LIT_HI  = 7;
  localparam int LIT_LO  = 0;

  // Opcodes 0000..OP_ALU_LAST are ALU operations and go through WRITEBACK
  localparam logic [3:0] OP_ALU_LAST = 4'b0111;
  localparam logic [3:0] OP_JMP      = 4'b1000;
  localparam logic [3:0] OP_JZ       = 4'b1001;
  localparam logic [3:0] OP_HALT     = 4'b1111;

  // instruction_type bit0 selects the B operand source, bit1 selects the destination
  localparam int   TYPE_SRC_BIT  = 0;
  localparam int   TYPE_DST_BIT  = 1;
  localparam logic TYPE_LITERAL  = 1'b0;
  localparam logic TYPE_REGISTER = 1'b1;

  function automatic logic is_alu_op(input logic [3:0] op);
    return op <= OP_ALU_LAST;
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: instruction-memory fetch bus.
//   imem_req  : fetch request (sequencer -> memory)
//   imem_addr : fetch address (sequencer -> memory)
//   imem_ack  : fetch data valid this cycle (memory -> sequencer)
//   imem_data : 16-bit instruction word (memory -> sequencer)
// master = sequencer side, slave = instruction memory side.
interface cpu_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_ack;
  logic [15:0]      imem_data;

  modport master (output imem_req, imem_addr, input imem_ack, imem_data);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_data);
endinterface

// File: rtl/cpu_sequencer_program_counter.sv
// program_counter: the core's PC register.
//   clk, reset_n : clock and asynchronous active-low reset (PC -> RESET_PC)
//   load         : load load_value (takes priority over inc)
//   inc          : advance by one, wrapping 8'hFF -> 8'h00
//   load_value   : jump target
//   pc           : current program counter
module program_counter #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             inc,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] pc
);

  logic [WIDTH-1:0] pc_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_reg <= RESET_PC;
    end else if (load) begin
      pc_reg <= load_value;
    end else if (inc) begin
      pc_reg <= pc_reg + WIDTH'(1);  // natural modulo-2^WIDTH wrap
    end
  end

  assign pc = pc_reg;

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK control sequencer.
//   clk, reset_n       : clock, asynchronous active-low reset
//   run                : permission to start the next fetch
//   imem               : fetch bus (master side)
//   alu_zero           : ALU zero flag, consulted by JZ in EXECUTE
//   instruction_type   : IR[15:14] to ALU B mux / destination select
//   literal_or_address : IR[7:0]
//   alu_op             : IR[13:10]
//   rf_we, w_we        : one-cycle write strobes, WRITEBACK only
//   halted             : core stopped by HALT until reset
// All outputs come from state_reg, ir_reg or the PC, never from imem_ack.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter int         WIDTH    = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                run,
  cpu_sequencer_if.master     imem,
  input  logic                alu_zero,
  output logic [1:0]          instruction_type,
  output logic [WIDTH-1:0]    literal_or_address,
  output logic [3:0]          alu_op,
  output logic                rf_we,
  output logic                w_we,
  output logic                halted
);

  state_t               state_reg;
  state_t               state_next;
  logic [INSTR_W-1:0]   ir_reg;
  logic [WIDTH-1:0]     pc;
  logic [3:0]           ir_op;
  logic                 fetch_done;
  logic                 pc_load;
  logic                 imem_req_d;
  logic                 unused_rsvd;

  assign ir_op       = ir_reg[OP_HI:OP_LO];
  assign unused_rsvd = ^ir_reg[RSV_HI:RSV_LO];

  // An ack counts only while a request is actually outstanding
  assign fetch_done = (state_reg == ST_FETCH) && imem.imem_ack;
  assign pc_load    = (state_reg == ST_EXECUTE) &&
                      ((ir_op == OP_JMP) || ((ir_op == OP_JZ) && alu_zero));

  program_counter #(
    .WIDTH    (WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (pc_load),
    .inc        (fetch_done),
    .load_value (ir_reg[LIT_HI:LIT_LO]),
    .pc         (pc)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Instruction register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_reg <= '0;
    end else if (fetch_done) begin
      ir_reg <= imem.imem_data;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:      if (run) state_next = ST_FETCH;
      ST_FETCH:     if (imem.imem_ack) state_next = ST_DECODE;
      ST_DECODE:    state_next = ST_EXECUTE;
      ST_EXECUTE: begin
        if (is_alu_op(ir_op))      state_next = ST_WRITEBACK;
        else if (ir_op == OP_HALT) state_next = ST_HALT;
        else                       state_next = ST_IDLE;  // JMP, JZ, NOP range
      end
      ST_WRITEBACK: state_next = ST_IDLE;
      ST_HALT:      state_next = ST_HALT;
      default:      state_next = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    imem_req_d = 1'b0;
    rf_we      = 1'b0;
    w_we       = 1'b0;
    halted     = 1'b0;
    case (state_reg)
      ST_FETCH: imem_req_d = 1'b1;
      ST_WRITEBACK: begin
        if (ir_reg[TYPE_LO + TYPE_DST_BIT] == TYPE_REGISTER) rf_we = 1'b1;
        else                                                 w_we  = 1'b1;
      end
      ST_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign imem.imem_req   = imem_req_d;
  assign imem.imem_addr  = pc;

  // IR fields hold the last fetched instruction; IR is zero out of reset
  assign instruction_type   = ir_reg[TYPE_HI:TYPE_LO];
  assign literal_or_address = ir_reg[LIT_HI:LIT_LO];
  assign alu_op             = ir_op;

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;

  typedef struct {
    logic [15:0] instr;
    int          lat;
    logic        zero;
    logic [7:0]  addr;
    logic [7:0]  next;
    int          rf;
    int          w;
    logic        halt;
  } vec_t;

  typedef struct {
    logic [7:0] next;
    int         rf;
    int         w;
    logic       halt;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       run = 1'b0;
  logic       alu_zero = 1'b0;
  logic [1:0] instruction_type;
  logic [7:0] literal_or_address;
  logic [3:0] alu_op;
  logic       rf_we;
  logic       w_we;
  logic       halted;

  int n_pass  = 0;
  int n_total = 0;

  exp_t exp_q[$];
  vec_t vecs[11];

  cpu_sequencer_if #(.WIDTH(8)) bus();

  cpu_sequencer #(
    .RESET_PC (8'h00),
    .WIDTH    (8)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .run                (run),
    .imem               (bus),
    .alu_zero           (alu_zero),
    .instruction_type   (instruction_type),
    .literal_or_address (literal_or_address),
    .alu_op             (alu_op),
    .rf_we              (rf_we),
    .w_we               (w_we),
    .halted             (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Runs one instruction: waits for the request, answers after v.lat request
  // cycles, then watches strobes until the next request or HALT.
  task automatic run_instr(input vec_t v);
    int   n;
    int   req_cycles;
    int   rf_cnt;
    int   w_cnt;
    int   both;
    int   strobe_pos;
    int   end_pos;
    logic got_req;
    logic got_halt;
    exp_t e;

    n = 0;
    while (!bus.imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_start", {31'd0, bus.imem_req}, 32'd1);
    check("fetch_addr", {24'd0, bus.imem_addr}, {24'd0, v.addr});

    req_cycles = 0;
    for (int k = 1; k <= v.lat; k++) begin
      if (bus.imem_req) req_cycles++;
      if (k == v.lat) begin
        bus.imem_ack  = 1'b1;
        bus.imem_data = v.instr;
        exp_q.push_back('{next: v.next, rf: v.rf, w: v.w, halt: v.halt});
      end
      @(negedge clk);
    end
    bus.imem_ack  = 1'b0;
    bus.imem_data = 16'hDEAD;
    check("req_cycles", req_cycles, v.lat);

    // DECODE cycle
    check("dec_req", {31'd0, bus.imem_req}, 32'd0);
    check("dec_type", {30'd0, instruction_type}, {30'd0, v.instr[15:14]});
    check("dec_lit", {24'd0, literal_or_address}, {24'd0, v.instr[7:0]});
    check("dec_op", {28'd0, alu_op}, {28'd0, v.instr[13:10]});
    alu_zero = v.zero;

    rf_cnt = 0; w_cnt = 0; both = 0; strobe_pos = -1; end_pos = -1;
    got_req = 1'b0; got_halt = 1'b0;
    for (int p = 0; p < 8; p++) begin
      @(negedge clk);  // p = 0 is EXECUTE
      if (rf_we) rf_cnt++;
      if (w_we) w_cnt++;
      if (rf_we && w_we) both++;
      if ((rf_we || w_we) && strobe_pos < 0) strobe_pos = p;
      if (bus.imem_req || halted) begin
        got_req  = bus.imem_req;
        got_halt = halted;
        end_pos  = p;
        break;
      end
    end
    alu_zero = 1'b0;

    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("rf_we_count", rf_cnt, e.rf);
      check("w_we_count", w_cnt, e.w);
      check("strobe_overlap", both, 0);
      check("halted", {31'd0, got_halt}, {31'd0, e.halt});
      if (e.halt) begin
        check("halt_pos", end_pos, 1);
        check("halt_no_req", {31'd0, got_req}, 32'd0);
      end else begin
        check("next_req", {31'd0, got_req}, 32'd1);
        check("next_addr", {24'd0, bus.imem_addr}, {24'd0, e.next});
        check("next_req_pos", end_pos, (e.rf + e.w) != 0 ? 3 : 2);
        if ((e.rf + e.w) != 0) check("strobe_pos", strobe_pos, 1);
      end
      $display("instr %04h @%02h lat=%0d: rf_we=%0d w_we=%0d halted=%0b next=%02h",
               v.instr, v.addr, v.lat, rf_cnt, w_cnt, got_halt, bus.imem_addr);
    end
  endtask

  initial begin
    int bad;
    int n;

    bus.imem_ack  = 1'b0;
    bus.imem_data = 16'hDEAD;

    //            instr     lat zero addr   next   rf w halt
    vecs[0]  = '{16'h0105, 1, 1'b0, 8'h00, 8'h01, 0, 1, 1'b0};  // ALU, literal, -> W
    vecs[1]  = '{16'hC0AA, 3, 1'b0, 8'h01, 8'h02, 1, 0, 1'b0};  // type 11, slow ack, -> RF
    vecs[2]  = '{16'h2042, 1, 1'b0, 8'h02, 8'h42, 0, 0, 1'b0};  // JMP 42
    vecs[3]  = '{16'h2410, 2, 1'b1, 8'h42, 8'h10, 0, 0, 1'b0};  // JZ taken
    vecs[4]  = '{16'h2410, 1, 1'b0, 8'h10, 8'h11, 0, 0, 1'b0};  // JZ not taken
    vecs[5]  = '{16'h4C33, 2, 1'b0, 8'h11, 8'h12, 0, 1, 1'b0};  // type 01, op 3, -> W
    vecs[6]  = '{16'h9877, 1, 1'b0, 8'h12, 8'h13, 1, 0, 1'b0};  // type 10, op 6, -> RF
    vecs[7]  = '{16'h2BFF, 1, 1'b1, 8'h13, 8'h14, 0, 0, 1'b0};  // NOP (op 1010)
    vecs[8]  = '{16'h20FF, 1, 1'b0, 8'h14, 8'hFF, 0, 0, 1'b0};  // JMP FF
    vecs[9]  = '{16'h0001, 1, 1'b0, 8'hFF, 8'h00, 0, 1, 1'b0};  // fetch at FF wraps PC
    vecs[10] = '{16'h3C00, 1, 1'b0, 8'h00, 8'h00, 0, 0, 1'b1};  // HALT

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req", {31'd0, bus.imem_req}, 32'd0);
    check("rst_addr", {24'd0, bus.imem_addr}, 32'h00);
    check("rst_type", {30'd0, instruction_type}, 32'd0);
    check("rst_lit", {24'd0, literal_or_address}, 32'd0);
    check("rst_op", {28'd0, alu_op}, 32'd0);
    check("rst_we", {30'd0, rf_we, w_we}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);

    reset_n = 1'b1;
    run     = 1'b1;

    for (int i = 0; i < 11; i++) run_instr(vecs[i]);

    // HALT holds for 20 cycles despite run and stray acks
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      bus.imem_ack = c[0];
      @(negedge clk);
      if (bus.imem_req || !halted || rf_we || w_we) bad++;
    end
    bus.imem_ack = 1'b0;
    check("halt_hold", bad, 0);

    // Reset asserted during an outstanding fetch
    reset_n = 1'b0;
    run     = 1'b0;
    @(negedge clk);
    check("rst2_halted", {31'd0, halted}, 32'd0);
    reset_n = 1'b1;
    run     = 1'b1;
    n = 0;
    while (!bus.imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst3_req", {31'd0, bus.imem_req}, 32'd1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_req_drop", {31'd0, bus.imem_req}, 32'd0);
    check("async_pc", {24'd0, bus.imem_addr}, 32'h00);
    run = 1'b0;
    @(negedge clk);
    reset_n       = 1'b1;
    bus.imem_ack  = 1'b1;
    bus.imem_data = 16'h20AA;
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.imem_req || bus.imem_addr != 8'h00 || literal_or_address != 8'h00) bad++;
    end
    bus.imem_ack  = 1'b0;
    bus.imem_data = 16'hDEAD;
    check("late_ack_ignored", bad, 0);
    run = 1'b1;
    run_instr('{16'h0105, 1, 1'b0, 8'h00, 8'h01, 0, 1, 1'b0});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global time bound so the bench always terminates
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "timeout");
  end

endmodule
